// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I opcode, funct7 and instruction-class definitions
package rv32_pkg;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_L     = 7'h03;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_J     = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_SYS   = 7'h73;

  localparam logic [6:0] F7_BASE  = 7'h00;
  localparam logic [6:0] F7_ALT   = 7'h20;

  typedef enum logic [3:0] {
    CLS_R     = 4'd0,
    CLS_I     = 4'd1,
    CLS_L     = 4'd2,
    CLS_S     = 4'd3,
    CLS_B     = 4'd4,
    CLS_J     = 4'd5,
    CLS_JALR  = 4'd6,
    CLS_LUI   = 4'd7,
    CLS_AUIPC = 4'd8,
    CLS_SYS   = 4'd9
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_FULL = 2'd3
  } ld_state_e;

endpackage

// File: rtl/rv32_field_pack.sv
// rtl/rv32_field_pack.sv - combinational packing of decoded RV32I fields into an instruction word
module rv32_field_pack
  import rv32_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic [6:0] f7;
  logic       imm12_ok;
  logic       imm13_ok;
  logic       imm21_ok;
  logic       shift_f3;
  logic       alt_ok;

  assign f7       = alt ? F7_ALT : F7_BASE;
  // Range checks: the value must be the sign extension of its low N bits.
  assign imm12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign imm13_ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
  assign imm21_ok = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
  assign shift_f3 = (funct3 == 3'd1) || (funct3 == 3'd5);
  // alt only selects funct7=0x20 for sub/sra and srai.
  assign alt_ok   = !alt
                  || ((cls == CLS_R) && ((funct3 == 3'd0) || (funct3 == 3'd5)))
                  || ((cls == CLS_I) && (funct3 == 3'd5));

  // Format selection and per-class legality.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (cls)
      CLS_R: begin
        word = {f7, rs2, rs1, funct3, rd, OP_R};
      end
      CLS_I: begin
        if (shift_f3) begin
          word    = {f7, imm[4:0], rs1, funct3, rd, OP_I};
          illegal = (imm[31:5] != '0);
        end else begin
          word    = {imm[11:0], rs1, funct3, rd, OP_I};
          illegal = !imm12_ok;
        end
      end
      CLS_L: begin
        word    = {imm[11:0], rs1, funct3, rd, OP_L};
        illegal = !imm12_ok || (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
      end
      CLS_S: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
        illegal = !imm12_ok || (funct3 > 3'd2);
      end
      CLS_B: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
        illegal = !imm13_ok || (funct3[2:1] == 2'b01);
      end
      CLS_J: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
        illegal = !imm21_ok;
      end
      CLS_JALR: begin
        word    = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        illegal = !imm12_ok;
      end
      CLS_LUI: begin
        word    = {imm[31:12], rd, OP_LUI};
        illegal = (imm[11:0] != '0);
      end
      CLS_AUIPC: begin
        word    = {imm[31:12], rd, OP_AUIPC};
        illegal = (imm[11:0] != '0);
      end
      CLS_SYS: begin
        // imm 0 -> ecall, imm 1 -> ebreak (bit 20)
        word    = {11'd0, imm[0], 13'd0, OP_SYS};
        illegal = (imm[31:1] != '0) || (funct3 != 3'd0);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    if (!alt_ok) illegal = 1'b1;
  end

endmodule

// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - streams encoded RV32I words into instruction memory at consecutive addresses
module inst_encoder_loader
  import rv32_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  ld_state_e         state, state_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic [ADDR_W:0]   cnt_d;
  logic              err_d;
  logic              pend_last, pend_last_d;

  logic [31:0]       pk_word;
  logic              pk_illegal;
  logic              retire;
  logic              xfer;
  logic              at_top;

  rv32_field_pack u_pack (
    .cls     (in_class),
    .funct3  (in_funct3),
    .alt     (in_alt),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (pk_word),
    .illegal (pk_illegal)
  );

  assign retire = imem_we && imem_ready;
  assign at_top = (imem_addr == ADDR_TOP);
  // Intake pauses while the pending write is the program's last word or
  // occupies the final slot: either retirement leaves LOAD, so a bundle taken
  // alongside it would be lost or would wrap onto address 0. A start in the
  // same cycle would discard the bundle, so it is not offered then either.
  assign in_ready = (state == ST_LOAD) && !start
                  && (!imem_we || (imem_ready && !pend_last && !at_top));
  assign xfer     = in_valid && in_ready;
  assign busy     = (state == ST_LOAD) || imem_we;
  assign full     = (state == ST_FULL);

  // Next-state and next-datapath decisions; start overrides everything.
  always_comb begin
    state_d     = state;
    we_d        = imem_we;
    addr_d      = imem_addr;
    wdata_d     = imem_wdata;
    cnt_d       = word_cnt;
    err_d       = err;
    pend_last_d = pend_last;
    if (start) begin
      state_d     = ST_LOAD;
      we_d        = 1'b0;
      addr_d      = '0;
      cnt_d       = '0;
      err_d       = 1'b0;
      pend_last_d = 1'b0;
    end else if (state == ST_LOAD) begin
      if (retire) begin
        we_d        = 1'b0;
        addr_d      = imem_addr + ADDR_ONE;
        cnt_d       = word_cnt + CNT_ONE;
        pend_last_d = 1'b0;
        if (pend_last) begin
          state_d = ST_DONE;
        end else if (at_top) begin
          state_d = ST_FULL;
        end
      end
      if (xfer) begin
        if (pk_illegal) begin
          // Consumed but never written; a last flag still ends the program.
          // Any pending write retires this same cycle because in_ready required it.
          err_d = 1'b1;
          if (in_last) state_d = ST_DONE;
        end else begin
          we_d        = 1'b1;
          wdata_d     = pk_word;
          pend_last_d = in_last;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Write port, counters and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_cnt   <= '0;
      err        <= 1'b0;
      pend_last  <= 1'b0;
    end else begin
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      word_cnt   <= cnt_d;
      err        <= err_d;
      pend_last  <= pend_last_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb/tb_inst_encoder_loader.sv - self-checking bench for inst_encoder_loader
module tb_inst_encoder_loader;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [3:0]  in_class = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_alt = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        imem_ready = 1'b1;
  logic        sel = 1'b0;
  logic        rdy_rand = 1'b0;

  logic        b_in_valid, b_in_ready, b_we, b_busy, b_full, b_err;
  logic [9:0]  b_addr;
  logic [31:0] b_wdata;
  logic [10:0] b_cnt;
  logic        s_in_valid, s_in_ready, s_we, s_busy, s_full, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_cnt;

  logic        m_ready, m_we, m_busy;
  logic [31:0] m_wdata;
  logic [9:0]  m_addr;

  int          ntests = 0;
  int          nfail = 0;
  logic [31:0] expq[$];
  int          exp_addr = 0;
  int          exp_legal = 0;
  logic        exp_err = 1'b0;
  logic [31:0] mem [0:1023];

  assign b_in_valid = in_valid && !sel;
  assign s_in_valid = in_valid && sel;
  assign m_ready = sel ? s_in_ready : b_in_ready;
  assign m_we    = sel ? s_we : b_we;
  assign m_busy  = sel ? s_busy : b_busy;
  assign m_wdata = sel ? s_wdata : b_wdata;
  assign m_addr  = sel ? {8'd0, s_addr} : b_addr;

  inst_encoder_loader #(.ADDR_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_last(in_last), .in_class(in_class), .in_funct3(in_funct3), .in_alt(in_alt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(b_we), .imem_ready(imem_ready), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .busy(b_busy), .full(b_full), .err(b_err), .word_cnt(b_cnt)
  );

  inst_encoder_loader #(.ADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_last(in_last), .in_class(in_class), .in_funct3(in_funct3), .in_alt(in_alt),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(s_we), .imem_ready(imem_ready), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .busy(s_busy), .full(s_full), .err(s_err), .word_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoder written directly from the RV32I format tables.
  function automatic void model(input logic [3:0] c, input logic [2:0] f3, input logic alt,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] u, output logic [31:0] w, output logic ill);
    int s;
    logic [31:0] f7w;
    s = $signed(u);
    ill = 1'b0;
    w = '0;
    f7w = alt ? 32'h4000_0000 : 32'h0;
    if (alt && !((c == CLS_R && (f3 == 3'd0 || f3 == 3'd5)) || (c == CLS_I && f3 == 3'd5))) ill = 1'b1;
    case (c)
      CLS_R: w = f7w | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h33;
      CLS_I: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          if (s < 0 || s > 31) ill = 1'b1;
          w = f7w | ((u & 32'h1f) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
        end else begin
          if (s < -2048 || s > 2047) ill = 1'b1;
          w = ((u & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h13;
        end
      end
      CLS_L: begin
        if (s < -2048 || s > 2047 || f3 == 3'd3 || f3 >= 3'd6) ill = 1'b1;
        w = ((u & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'h03;
      end
      CLS_JALR: begin
        if (s < -2048 || s > 2047) ill = 1'b1;
        w = ((u & 32'hfff) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h67;
      end
      CLS_S: begin
        if (s < -2048 || s > 2047 || f3 > 3'd2) ill = 1'b1;
        w = (((u >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
          | ((u & 32'h1f) << 7) | 32'h23;
      end
      CLS_B: begin
        if (s < -4096 || s > 4094 || u[0] || f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
          | (32'(f3) << 12) | (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      end
      CLS_J: begin
        if (s < -1048576 || s > 1048574 || u[0]) ill = 1'b1;
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) | (((u >> 11) & 1) << 20)
          | (((u >> 12) & 32'hff) << 12) | (32'(rd) << 7) | 32'h6f;
      end
      CLS_LUI, CLS_AUIPC: begin
        if ((u & 32'hfff) != 0) ill = 1'b1;
        w = (u & 32'hfffff000) | (32'(rd) << 7) | ((c == CLS_LUI) ? 32'h37 : 32'h17);
      end
      CLS_SYS: begin
        if (f3 != 3'd0 || s < 0 || s > 1) ill = 1'b1;
        w = (s == 1) ? 32'h0010_0073 : 32'h0000_0073;
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Scoreboard: handshakes and write retirements seen between clock edges.
  always @(negedge clk) begin
    logic [31:0] w;
    logic        ill;
    if (rst_n && !start) begin
      if (m_we && imem_ready) begin
        chk("write_expected", 64'(expq.size() > 0), 64'd1);
        if (expq.size() > 0) begin
          w = expq.pop_front();
          chk("wdata", m_wdata, w);
          chk("waddr", m_addr, sel ? (exp_addr % 4) : (exp_addr % 1024));
          mem[m_addr] = m_wdata;
          exp_addr++;
        end
      end
      if (in_valid && m_ready) begin
        model(in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, w, ill);
        if (ill) exp_err = 1'b1;
        else begin
          expq.push_back(w);
          exp_legal++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) imem_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    expq.delete();
    exp_addr = 0;
    exp_legal = 0;
    exp_err = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic set_fields(input logic [3:0] c, input logic [2:0] f3, input logic alt,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm, input logic last);
    in_class = c; in_funct3 = f3; in_alt = alt; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_last = last; in_valid = 1'b1;
  endtask

  task automatic wait_xfer(input string tag);
    bit ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (m_ready) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_accepted"}, 64'(ok), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send(input logic [3:0] c, input logic [2:0] f3, input logic alt,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic last, input string tag);
    set_fields(c, f3, alt, rd, rs1, rs2, imm, last);
    wait_xfer(tag);
  endtask

  task automatic drain(input string tag);
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!m_busy) begin
        ok = 1;
        break;
      end
    end
    chk({tag, "_drained"}, 64'(ok), 64'd1);
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] imm;
    int          r;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", b_we, 0);
    chk("rst_addr", b_addr, 0);
    chk("rst_wdata", b_wdata, 0);
    chk("rst_cnt", b_cnt, 0);
    chk("rst_err", b_err, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_full", b_full, 0);
    chk("rst_in_ready", b_in_ready, 0);
    rst_n = 1'b1;

    // Directed program, back-to-back with memory always ready.
    do_start();
    send(CLS_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, "addi");
    chk("lat_we", b_we, 1);
    chk("lat_addr", b_addr, 0);
    chk("lat_wdata", b_wdata, 32'h00500093);
    send(CLS_R, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, "sub");
    send(CLS_S, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12, 1'b0, "sw");
    send(CLS_B, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, "beq");
    send(CLS_J, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0, "jal");
    send(CLS_LUI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, "lui");
    drain("dir");
    chk("dir_mem0", mem[0], 32'h00500093);
    chk("dir_mem1", mem[1], 32'h402081B3);
    chk("dir_mem2", mem[2], 32'h0020A623);
    chk("dir_mem3", mem[3], 32'h00208463);
    chk("dir_mem4", mem[4], 32'h010000EF);
    chk("dir_mem5", mem[5], 32'h123452B7);
    chk("dir_cnt", b_cnt, 6);
    chk("dir_addr", b_addr, 6);
    chk("dir_err", b_err, 0);

    // Backpressure: memory stalls three cycles with a bundle waiting.
    do_start();
    imem_ready = 1'b0;
    send(CLS_I, 3'd0, 1'b0, 5'd2, 5'd1, 5'd0, 32'hFFFFFFFF, 1'b0, "stall_a");
    set_fields(CLS_I, 3'd0, 1'b0, 5'd3, 5'd2, 5'd0, 32'd100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", b_in_ready, 0);
      chk("stall_we", b_we, 1);
      chk("stall_addr", b_addr, 0);
      chk("stall_wdata", b_wdata, 32'hFFF08113);
    end
    @(posedge clk);
    #1 imem_ready = 1'b1;
    wait_xfer("stall_b");
    send(CLS_SYS, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd1, 1'b1, "ebreak");
    drain("stall");
    chk("stall_mem0", mem[0], 32'hFFF08113);
    chk("stall_mem1", mem[1], 32'h06410193);
    chk("stall_mem2", mem[2], 32'h00100073);
    chk("stall_cnt", b_cnt, 3);

    // Illegal bundles: consumed, flagged, never written.
    do_start();
    send(CLS_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, "ill_addi");
    chk("ill_err_sticky", b_err, 1);
    send(CLS_B, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd7, 1'b1, "ill_beq");
    drain("ill");
    chk("ill_cnt", b_cnt, 0);
    chk("ill_addr", b_addr, 0);
    chk("ill_err", b_err, 1);

    // Randomized program under random memory backpressure.
    do_start();
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      c = 4'($urandom_range(0, 10));
      in_funct3 = 3'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      case (c)
        CLS_I, CLS_L, CLS_S, CLS_JALR: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        CLS_B: imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
        CLS_J: imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
        CLS_LUI, CLS_AUIPC: imm = $urandom & 32'hFFFFF000;
        CLS_SYS: imm = 32'($urandom_range(0, 1));
        default: imm = $urandom;
      endcase
      if (c == CLS_I && (in_funct3 == 3'd1 || in_funct3 == 3'd5)) imm = 32'($urandom_range(0, 31));
      if (r == 0) imm = $urandom;
      if (r == 1) imm = imm + 32'd1;
      send(c, in_funct3, 1'($urandom_range(0, 5) == 0), 5'($urandom), 5'($urandom), 5'($urandom),
           imm, 1'(i == 299), "rnd");
    end
    drain("rnd");
    rdy_rand = 1'b0;
    @(posedge clk);
    #1 imem_ready = 1'b1;
    chk("rnd_cnt", b_cnt, exp_legal);
    chk("rnd_err", b_err, exp_err);
    chk("rnd_queue_empty", expq.size(), 0);

    // Capacity limit on the 4-word instance.
    sel = 1'b1;
    do_start();
    for (int i = 0; i < 4; i++)
      send(CLS_I, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0, "full_w");
    set_fields(CLS_I, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'd9, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("full_5th_blocked", s_in_ready, 0);
    end
    chk("full_flag", s_full, 1);
    chk("full_cnt", s_cnt, 4);
    chk("full_addr", s_addr, 0);
    chk("full_busy", s_busy, 0);
    chk("full_writes", exp_addr, 4);
    @(posedge clk);
    #1 in_valid = 1'b0;
    do_start();
    chk("restart_full", s_full, 0);
    chk("restart_addr", s_addr, 0);
    chk("restart_cnt", s_cnt, 0);
    chk("restart_busy", s_busy, 1);
    sel = 1'b0;

    // Asynchronous reset while a write is held pending.
    do_start();
    imem_ready = 1'b0;
    send(CLS_I, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, "rst_w");
    chk("pre_rst_we", b_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", b_we, 0);
    chk("mid_rst_addr", b_addr, 0);
    chk("mid_rst_wdata", b_wdata, 0);
    chk("mid_rst_cnt", b_cnt, 0);
    chk("mid_rst_busy", b_busy, 0);
    chk("mid_rst_in_ready", b_in_ready, 0);
    expq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    imem_ready = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
